// File: rtl/sram_controller.sv
// sram_controller: sequences a 16-bit asynchronous SRAM for 32-bit loads and
// stores. Each access is split into a low-half and a high-half phase of
// WAIT_CYCLES clocks each; ready stays low for the whole access so the
// pipeline freezes until the DONE cycle.
//
// Handshake: a request (rd_en/wr_en) is accepted on any clock edge where the
// FSM is in IDLE; ready=1 in a cycle means the pipeline may advance on the
// next edge. The requester keeps the request stable until it sees ready=1,
// and the request still visible in DONE is the one just served, so it is
// not accepted again.
module sram_controller #(
  parameter int WAIT_CYCLES = 3,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [16:0] word_calc;
  logic        last_cycle;
  logic        busy;

  // Word index relative to the data-memory base; out-of-range addresses wrap.
  assign word_calc  = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign last_cycle = (cnt_q == LAST_CNT);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, phase counter, request latching, read capture and ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          state_d = LOW;
          cnt_d   = 4'd0;
          wr_d    = wr_en;   // write wins when both are requested
          word_d  = word_calc;
          wdata_d = write_data;
        end
      end
      LOW: begin
        if (last_cycle) begin
          cnt_d   = 4'd0;
          state_d = HIGH;
          if (!wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          cnt_d   = 4'd0;
          state_d = DONE;
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pins decode from registered state only; no path from sram_dq_in.
  assign busy        = (state_q == LOW) || (state_q == HIGH);
  assign sram_dq_oe  = busy & wr_q;
  assign sram_we_n   = ~(busy & wr_q);
  assign sram_addr   = {word_q, (state_q == HIGH)};
  assign sram_dq_out = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign read_data   = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed and random loads/stores against a behavioural
// SRAM device and a word-level memory model kept by the bench.
module tb_sram_controller;

  localparam int W    = 3;
  localparam int BASE = 1024;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side view of memory contents and the last loaded word.
  logic [15:0] exp_mem [0:255];
  logic [31:0] exp_rd;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503 + 12345);
  endfunction

  // Asynchronous SRAM device: combinational read; a write commits only after
  // the strobe has been held at one address for a full W-cycle pulse.
  logic [15:0] sram_mem [0:255];
  logic        mem_ready = 1'b0;
  logic [17:0] last_addr = 18'd0;
  int          run_cnt = 0;
  int          run_nxt;

  assign sram_dq_in = sram_mem[sram_addr[7:0]];
  assign run_nxt    = (sram_addr == last_addr && run_cnt != 0) ? run_cnt + 1 : 1;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (!sram_we_n) begin
      run_cnt   <= run_nxt;
      last_addr <= sram_addr;
      if (run_nxt == W) sram_mem[sram_addr[7:0]] <= sram_dq_out;
    end else begin
      run_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Holds requests low for n cycles and expects a quiet bus with ready high.
  task automatic idle_check(input string tag, input int n);
    rd_en = 1'b0;
    wr_en = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check({tag, " idle ready"}, 64'(ready), 64'd1);
      check({tag, " idle we_n"}, 64'(sram_we_n), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: presents one request (entered just after a rising edge), keeps it
  // up through the ready cycle like a frozen pipeline, then releases it.
  task automatic do_access(input string tag, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input bit scramble);
    logic [31:0] offs;
    logic [16:0] word;
    logic [7:0]  idx_lo;
    logic [7:0]  idx_hi;
    logic [31:0] exp_read;
    int          stall;
    int          oe_bad;
    bit          done;

    offs   = addr - BASE;
    word   = offs[18:2];
    idx_lo = {word[6:0], 1'b0};
    idx_hi = {word[6:0], 1'b1};
    exp_q.delete();
    got_q.delete();
    if (wr) begin
      for (int i = 0; i < W; i++) exp_q.push_back({word, 1'b0, data[15:0]});
      for (int i = 0; i < W; i++) exp_q.push_back({word, 1'b1, data[31:16]});
      exp_read = exp_rd;
    end else begin
      exp_read = {exp_mem[idx_hi], exp_mem[idx_lo]};
    end

    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    stall  = 0;
    oe_bad = 0;
    done   = 1'b0;
    for (int c = 0; c < 8 * W + 8 && !done; c++) begin
      @(negedge clk);
      if (!sram_we_n) got_q.push_back({sram_addr, sram_dq_out});
      if (sram_dq_oe !== !sram_we_n) oe_bad++;
      if (ready) done = 1'b1;
      else stall++;
      if (done) check({tag, " read_data"}, 64'(read_data), 64'(exp_read));
      @(posedge clk);
      #1;
      if (scramble && c == 1) begin
        address    = $urandom;
        write_data = $urandom;
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    check({tag, " done seen"}, 64'(done), 64'd1);
    check({tag, " stall cycles"}, 64'(stall), 64'(2 * W + 1));
    check({tag, " oe vs we_n"}, 64'(oe_bad), 64'd0);
    check({tag, " strobe count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, " strobe addr/data"}, 64'(got_q[i]), 64'(exp_q[i]));

    if (wr) begin
      exp_mem[idx_lo] = data[15:0];
      exp_mem[idx_hi] = data[31:16];
    end else begin
      exp_rd = exp_read;
    end
  endtask

  // Directed steps followed by randomized traffic, then the report.
  initial begin
    int op;
    logic [31:0] a;
    logic [31:0] d;

    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    exp_rd     = 32'd0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;

    @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(ready), 64'd1);
    check("reset we_n", 64'(sram_we_n), 64'd1);
    check("reset oe", 64'(sram_dq_oe), 64'd0);
    check("reset read_data", 64'(read_data), 64'd0);
    check("reset sram_addr", 64'(sram_addr), 64'd0);
    check("reset dq_out", 64'(sram_dq_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle ready", 64'(ready), 64'd1);
      check("idle we_n", 64'(sram_we_n), 64'd1);
      check("idle oe", 64'(sram_dq_oe), 64'd0);
      check("idle read_data", 64'(read_data), 64'd0);
      @(posedge clk);
      #1;
    end

    do_access("store 1028", 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    do_access("load 1028", 1'b0, 1'b1, 32'd1028, 32'd0, 1'b0);
    check("load 1028 value", 64'(read_data), 64'hDEADBEEF);
    idle_check("after load", 2);

    do_access("rd+wr 1024", 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    check("rd+wr keeps read_data", 64'(read_data), 64'hDEADBEEF);

    // Reset during the high-half write phase.
    wr_en      = 1'b1;
    address    = 32'd1024;
    write_data = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    check("pre-reset hw1 strobe", 64'({sram_we_n, sram_addr}), 64'({1'b0, 18'd1}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", 64'(ready), 64'd1);
    check("post-reset we_n", 64'(sram_we_n), 64'd1);
    check("post-reset oe", 64'(sram_dq_oe), 64'd0);
    check("post-reset read_data", 64'(read_data), 64'd0);
    @(posedge clk);
    #1;
    exp_mem[0] = 16'hF00D;
    exp_rd     = 32'd0;
    do_access("load after reset", 1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    check("hw1 untouched", 64'(read_data[31:16]), 64'h1234);

    do_access("b2b load 1032", 1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
    do_access("b2b load 1036", 1'b0, 1'b1, 32'd1036, 32'd0, 1'b0);
    idle_check("after b2b", 3);

    do_access("store wrap 1020", 1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 1'b0);
    do_access("load wrap 1020", 1'b0, 1'b1, 32'd1020, 32'd0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      a  = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      d  = $urandom;
      do_access("random", op != 0, op != 1, a, d, 1'b1);
      if ($urandom_range(0, 2) == 0) idle_check("random gap", $urandom_range(1, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
